// File: rtl/cost_calculator.sv
// Sequential squared-error cost over NUM_CLASSES class weights, one class per cycle.
// Define COST_CALC_SATURATE_EN to make the 8-bit accumulator saturate at 255 instead of wrapping.
module cost_calculator #(
    parameter int NUM_CLASSES  = 10,
    parameter int TARGET_VALUE = 8
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             cost_en,
    input  logic [0:NUM_CLASSES-1]           expected_label,
    input  logic [0:NUM_CLASSES-1][3:0]      digit_weights,
    output logic                             calculation_complete,
    output logic [7:0]                       cost_output
);

    localparam int IW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CLASSES - 1);
    localparam logic [4:0] TARGET = 5'(TARGET_VALUE);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]                        state_q;
    logic [0:NUM_CLASSES-1]            label_q;
    logic [0:NUM_CLASSES-1][3:0]       weights_q;
    logic [7:0]                        acc_q;
    logic [IW-1:0]                     idx_q;

    logic [4:0] target;
    logic [4:0] weight5;
    logic [4:0] diff5;
    logic [3:0] diff;
    logic [7:0] square;
    logic [7:0] term;
    logic [7:0] acc_next;

    always_comb begin
        target  = label_q[idx_q] ? TARGET : 5'd0;
        weight5 = {1'b0, weights_q[idx_q]};
        diff5   = (target >= weight5) ? (target - weight5) : (weight5 - target);
        diff    = diff5[3:0];
        square  = {4'd0, diff} * {4'd0, diff};
        // Only bits [6:2] of the square contribute to the cost.
        term    = {3'd0, square[6:2]};
    end

`ifdef COST_CALC_SATURATE_EN
    logic [8:0] sum9;
    always_comb begin
        sum9     = {1'b0, acc_q} + {1'b0, term};
        acc_next = sum9[8] ? 8'hFF : sum9[7:0];
    end
`else
    always_comb begin
        acc_next = acc_q + term;
    end
`endif

    logic unused_bits;
    assign unused_bits = ^{square[7], square[1:0], diff5[4]};

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state_q              <= IDLE;
            label_q              <= '0;
            weights_q            <= '0;
            acc_q                <= 8'd0;
            idx_q                <= '0;
            cost_output          <= 8'd0;
            calculation_complete <= 1'b0;
        end else begin
            calculation_complete <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cost_en) begin
                        label_q   <= expected_label;
                        weights_q <= digit_weights;
                        acc_q     <= 8'd0;
                        idx_q     <= '0;
                        state_q   <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_next;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    cost_output          <= acc_q;
                    calculation_complete <= 1'b1;
                    state_q              <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cost_calculator.sv
// Directed-vector bench for cost_calculator: fixed latency, hand-computed costs, reset abort.
module tb_cost_calculator;

    logic              tb_clk;
    logic              n_rst;
    logic              cost_en;
    logic [0:9]        expected_label;
    logic [0:9][3:0]   digit_weights;
    logic              calculation_complete;
    logic [7:0]        cost_output;

    int checks;
    int errors;
    logic [7:0] last_cost;

    cost_calculator #(
        .NUM_CLASSES  (10),
        .TARGET_VALUE (8)
    ) dut (
        .clk                  (tb_clk),
        .n_rst                (n_rst),
        .cost_en              (cost_en),
        .expected_label       (expected_label),
        .digit_weights        (digit_weights),
        .calculation_complete (calculation_complete),
        .cost_output          (cost_output)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [0:9][3:0] fill(input logic [3:0] v);
        logic [0:9][3:0] w;
        for (int i = 0; i < 10; i++) w[i] = v;
        return w;
    endfunction

    // Starts one calculation and checks timing and result; inputs are scrambled after the
    // start edge, and mid_pulse re-asserts cost_en during CALC.
    task automatic run_op(input string tag, input logic [0:9] lbl, input logic [0:9][3:0] w,
                          input logic [7:0] exp, input bit mid_pulse);
        @(negedge tb_clk);
        expected_label = lbl;
        digit_weights  = w;
        cost_en        = 1'b1;
        @(posedge tb_clk);                       // edge k
        @(negedge tb_clk);
        cost_en        = 1'b0;
        expected_label = ~lbl;
        digit_weights  = fill(4'hF);
        for (int e = 1; e <= 10; e++) begin
            @(posedge tb_clk);
            if (mid_pulse && e == 3) begin
                @(negedge tb_clk);
                cost_en = 1'b1;
            end
            if (mid_pulse && e == 4) begin
                @(negedge tb_clk);
                cost_en = 1'b0;
            end
        end
        #1;                                      // just after edge k+10
        check({tag, " busy_complete"}, 32'(calculation_complete), 32'd0);
        check({tag, " busy_hold"}, 32'(cost_output), 32'(last_cost));
        @(posedge tb_clk); #1;                   // edge k+11
        check({tag, " complete"}, 32'(calculation_complete), 32'd1);
        check({tag, " cost"}, 32'(cost_output), 32'(exp));
        @(posedge tb_clk); #1;
        check({tag, " one_pulse"}, 32'(calculation_complete), 32'd0);
        check({tag, " cost_hold"}, 32'(cost_output), 32'(exp));
        last_cost = exp;
    endtask

    initial begin
        logic [0:9]      lbl;
        logic [0:9][3:0] w;
        logic [7:0]      exp_wrap;
        int              pulses;

        checks         = 0;
        errors         = 0;
        last_cost      = 8'd0;
        n_rst          = 1'b1;
        cost_en        = 1'b0;
        expected_label = '0;
        digit_weights  = '0;

        repeat (2) @(posedge tb_clk);
        #1;
        check("reset_cost", 32'(cost_output), 32'd0);
        check("reset_complete", 32'(calculation_complete), 32'd0);
        @(negedge tb_clk);
        n_rst = 1'b0;
        @(posedge tb_clk); #1;
        check("release_cost", 32'(cost_output), 32'd0);
        check("release_complete", 32'(calculation_complete), 32'd0);

        lbl = 10'b0001000000;
        run_op("class3_w0", lbl, fill(4'd0), 8'd16, 1'b0);

        lbl = 10'b1000000000;
        run_op("class0_w8", lbl, fill(4'd8), 8'd144, 1'b0);

        lbl = 10'b0000010000;
        w = fill(4'd0);
        w[5] = 4'd8;
        run_op("class5_exact", lbl, w, 8'd0, 1'b0);

        lbl = 10'b0000000100;
        run_op("class7_w2", lbl, fill(4'd2), 8'd18, 1'b0);

        // Two labels set: classes 1 and 4 each contribute 16, others 0.
        lbl = 10'b0100100000;
        run_op("two_labels", lbl, fill(4'd0), 8'd32, 1'b0);

        // Weights of 15: target 8 gives d=7 -> 12, target 0 gives d=15 -> 24; 12 + 9*24 = 228.
        lbl = 10'b1000000000;
        run_op("w15_range", lbl, fill(4'hF), 8'd228, 1'b0);

        // No label, weights 11: ten terms of 30 = 300, overflows 8 bits.
`ifdef COST_CALC_SATURATE_EN
        exp_wrap = 8'd255;
`else
        exp_wrap = 8'd44;
`endif
        lbl = 10'b0000000000;
        run_op("overflow", lbl, fill(4'd11), exp_wrap, 1'b0);

        // cost_en re-pulsed during CALC must not restart or shift the result.
        lbl = 10'b0000000100;
        run_op("mid_pulse", lbl, fill(4'd2), 8'd18, 1'b1);

        // Reset in the middle of CALC aborts with no completion pulse.
        @(negedge tb_clk);
        expected_label = 10'b0001000000;
        digit_weights  = fill(4'd0);
        cost_en        = 1'b1;
        @(negedge tb_clk);
        cost_en = 1'b0;
        repeat (4) @(negedge tb_clk);
        #2;
        n_rst = 1'b1;
        #1;
        check("abort_cost_async", 32'(cost_output), 32'd0);
        check("abort_complete_async", 32'(calculation_complete), 32'd0);
        pulses = 0;
        repeat (3) begin
            @(posedge tb_clk); #1;
            if (calculation_complete) pulses++;
        end
        @(negedge tb_clk);
        n_rst = 1'b0;
        repeat (14) begin
            @(posedge tb_clk); #1;
            if (calculation_complete) pulses++;
        end
        check("abort_no_pulse", 32'(pulses), 32'd0);
        check("abort_cost_after", 32'(cost_output), 32'd0);
        last_cost = 8'd0;

        lbl = 10'b0000000100;
        run_op("fresh_after_abort", lbl, fill(4'd2), 8'd18, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
